// File: rtl/imem_sync.sv
//==============================================================================
// Module   : imem_sync
// Brief    : Synchronous instruction memory with a valid/ready fetch port
//            (one-cycle registered read, fault reporting) and a sequential
//            program-load port that streams words in at one per cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    // load port
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done
);

    // Byte-offset bits inside one word, and the width of a word index.
    localparam int c_byte_sh = $clog2(DATA_W / 8);
    localparam int c_idx_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic [31:0]          w_word_idx;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_misalign;
    logic                 w_oob;
    logic                 w_fault;
    logic                 w_fetch_acc;
    logic                 w_load_acc;
    logic                 w_load_term;

    // Word index is kept 32 bits wide so the range test also catches
    // addresses whose index does not fit in the array index width.
    assign w_word_idx = 32'(fetch_addr) >> c_byte_sh;
    assign w_idx      = w_word_idx[c_idx_w-1:0];
    assign w_oob      = (w_word_idx >= 32'(DEPTH));

    // Byte-wide words have no offset bits, so nothing can be misaligned.
    generate
        if (c_byte_sh == 0) begin : g_no_offset
            assign w_misalign = 1'b0;
        end else begin : g_offset_chk
            assign w_misalign = |fetch_addr[c_byte_sh-1:0];
        end
    endgenerate

    assign w_fault     = w_misalign | w_oob;

    // load_start wins over a same-cycle fetch so the mode switch is clean.
    assign fetch_ready = (r_state == ST_RUN) && !load_start;
    assign load_ready  = (r_state == ST_LOAD);

    assign w_fetch_acc = fetch_req && fetch_ready;
    assign w_load_acc  = load_valid && load_ready;
    // The last array slot always ends a load, so the pointer never wraps.
    assign w_load_term = w_load_acc && (load_last || (r_ptr == c_last_idx));

    // Program storage write; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_mem[r_ptr] <= load_data;
        end
    end

    // Mode FSM, load pointer and registered fetch/load status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ptr       <= '0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= '0;
            load_done   <= 1'b0;
        end else begin
            fetch_valid <= w_fetch_acc;
            fetch_fault <= w_fetch_acc && w_fault;
            if (w_fetch_acc) begin
                fetch_data <= w_fault ? NOP_WORD : r_mem[w_idx];
            end
            load_done <= w_load_term;

            case (r_state)
                ST_RUN: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_term) begin
                        r_state <= ST_RUN;
                    end else if (w_load_acc) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_sync.sv
//==============================================================================
// Module   : tb_imem_sync
// Brief    : Directed self-checking bench for imem_sync.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_sync;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;

    int errors = 0;
    int checks = 0;

    imem_sync #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        step();
        step();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fetch_fault got %b want 0", fetch_fault); end
        checks++; if (fetch_data !== 32'h0) begin errors++; $display("FAIL reset_fetch_data got %h want 00000000", fetch_data); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready got %b want 1", fetch_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_then_fetch();
        load_start = 1'b1;
        #1;
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL ld_start_blocks_fetch got %b want 0", fetch_ready); end
        step();
        load_start = 1'b0;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_in_load got %b want 1", load_ready); end
        load_valid = 1'b1; load_data = 32'h0010_0093; load_last = 1'b0;
        step();
        load_data = 32'h0020_0113;
        step();
        load_data = 32'h0030_8193; load_last = 1'b1;
        step();
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL ld_done_pulse got %b want 1", load_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_after_last got %b want 0", load_ready); end
        load_valid = 1'b0; load_last = 1'b0;
        step();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL ld_done_single got %b want 0", load_done); end
        fetch_req = 1'b1; fetch_addr = 10'h004;
        step();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch4_valid got %b want 1", fetch_valid); end
        checks++; if (fetch_data !== 32'h0020_0113) begin errors++; $display("FAIL fetch4_data got %h want 00200113", fetch_data); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fetch4_fault got %b want 0", fetch_fault); end
    endtask

    // Continues the fetch stream back-to-back from the previous task.
    task automatic test_misaligned();
        fetch_addr = 10'h006;
        step();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b want 1", fetch_valid); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b want 1", fetch_fault); end
        checks++; if (fetch_data !== NOP) begin errors++; $display("FAIL mis_data got %h want 00000013", fetch_data); end
        fetch_addr = 10'h008;
        step();
        checks++; if (fetch_data !== 32'h0030_8193) begin errors++; $display("FAIL fetch8_data got %h want 00308193", fetch_data); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fetch8_fault got %b want 0", fetch_fault); end
        fetch_req = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_data !== 32'h0030_8193) begin errors++; $display("FAIL idle_data_hold got %h want 00308193", fetch_data); end
    endtask

    task automatic test_out_of_range();
        fetch_req = 1'b1; fetch_addr = 10'h100;
        step();
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL oob64_fault got %b want 1", fetch_fault); end
        checks++; if (fetch_data !== NOP) begin errors++; $display("FAIL oob64_data got %h want 00000013", fetch_data); end
        fetch_addr = 10'h0FC;
        step();
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL idx63_fault got %b want 0", fetch_fault); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL idx63_valid got %b want 1", fetch_valid); end
        fetch_addr = 10'h3FD;
        step();
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL top_mis_fault got %b want 1", fetch_fault); end
        fetch_req = 1'b0;
        step();
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clears got %b want 0", fetch_fault); end
    endtask

    task automatic test_full_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(i + 1);
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL full_ready word %0d got %b want 1", i, load_ready); end
            step();
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", load_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop got %b want 0", load_ready); end
        load_data = 32'h0000_DEAD;
        step();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL full_extra_done got %b want 0", load_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_extra_ready got %b want 0", load_ready); end
        load_valid = 1'b0;
        fetch_req = 1'b1; fetch_addr = 10'h0FC;
        step();
        checks++; if (fetch_data !== 32'h0000_0040) begin errors++; $display("FAIL full_idx63 got %h want 00000040", fetch_data); end
        fetch_addr = 10'h000;
        step();
        checks++; if (fetch_data !== 32'h0000_0001) begin errors++; $display("FAIL full_idx0 got %h want 00000001", fetch_data); end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_priority_mid_reset();
        fetch_req = 1'b1; fetch_addr = 10'h000; load_start = 1'b1;
        #1;
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b want 0", fetch_ready); end
        step();
        fetch_req = 1'b0; load_start = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL prio_no_valid got %b want 0", fetch_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL prio_in_load got %b want 1", load_ready); end
        load_valid = 1'b1; load_data = 32'h0000_00A1;
        step();
        load_data = 32'h0000_00B2;
        step();
        load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_async_run got %b want 0", load_ready); end
        step();
        rst_n = 1'b1;
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", load_done); end
        step();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_no_done_late got %b want 0", load_done); end
        fetch_req = 1'b1; fetch_addr = 10'h004;
        step();
        checks++; if (fetch_data !== 32'h0000_00B2) begin errors++; $display("FAIL rst_idx1 got %h want 000000b2", fetch_data); end
        fetch_addr = 10'h008;
        step();
        checks++; if (fetch_data !== 32'h0000_0003) begin errors++; $display("FAIL rst_idx2_kept got %h want 00000003", fetch_data); end
        fetch_addr = 10'h000;
        step();
        checks++; if (fetch_data !== 32'h0000_00A1) begin errors++; $display("FAIL rst_idx0 got %h want 000000a1", fetch_data); end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_reset_inflight();
        fetch_req = 1'b1; fetch_addr = 10'h000;
        #1;
        rst_n = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL inflight_dropped got %b want 0", fetch_valid); end
        rst_n = 1'b1; fetch_req = 1'b0;
        step();
        // Single-word load lands at index 0, showing the pointer restarts.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'h0000_0055; load_last = 1'b1;
        step();
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL one_word_done got %b want 1", load_done); end
        load_valid = 1'b0; load_last = 1'b0;
        step();
        fetch_req = 1'b1; fetch_addr = 10'h000;
        step();
        checks++; if (fetch_data !== 32'h0000_0055) begin errors++; $display("FAIL one_word_idx0 got %h want 00000055", fetch_data); end
        fetch_addr = 10'h004;
        step();
        checks++; if (fetch_data !== 32'h0000_00B2) begin errors++; $display("FAIL one_word_idx1 got %h want 000000b2", fetch_data); end
        fetch_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load_then_fetch();
        test_misaligned();
        test_out_of_range();
        test_full_load();
        test_priority_mid_reset();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
